// File: rtl/wb_sram_loader_pkg.sv
// -----------------------------------------------------------------------------
// wb_sram_loader_pkg
// Shared definitions for the Wishbone SRAM loader bridge:
//   - region_t      : decode of wbs_adr_i[11:10] into the three macros + CTRL
//   - state_t       : loader FSM state encodings
//   - CTRL_HOLD_BIT : bit position of the hold flag in the CTRL register
//   - IDLE_*        : values driven onto a macro port when the loader is idle
//   - decode_region : helper that extracts the region field from a byte address
// -----------------------------------------------------------------------------
package wb_sram_loader_pkg;

    typedef enum logic [1:0] {
        REGION_IRAM_A = 2'b00,
        REGION_IRAM_B = 2'b01,
        REGION_DRAM   = 2'b10,
        REGION_CTRL   = 2'b11
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam int          CTRL_HOLD_BIT = 0;

    localparam logic        IDLE_CSB   = 1'b1;
    localparam logic        IDLE_WEB   = 1'b1;
    localparam logic [3:0]  IDLE_WMASK = 4'h0;
    localparam logic [31:0] IDLE_DIN   = 32'h0;

    function automatic region_t decode_region(input logic [31:0] adr);
        return region_t'(adr[11:10]);
    endfunction

endpackage

// File: rtl/wb_sram_loader_sram_port_mux.sv
// -----------------------------------------------------------------------------
// sram_port_mux
// Combinational select of one SRAM macro port 0 between the core and the
// Wishbone loader. While i_hold=1 the loader side drives the macro, otherwise
// the core side passes straight through.
//
// Ports:
//   i_hold                       : 1 = loader owns the port, 0 = core owns it
//   i_core_csb[NCS]/web/wmask/addr/din : core-side controls and data
//   i_ldr_csb[NCS]/web/wmask/addr/din  : loader-side controls and data
//   o_mac_csb[NCS]/web/wmask/addr/din  : signals to the macro(s)
// NCS is the number of chip selects sharing the remaining port signals
// (2 for the IRAM A/B pair, 1 for DRAM).
// -----------------------------------------------------------------------------
module sram_port_mux #(
    parameter int AW  = 8,
    parameter int NCS = 1
) (
    input  logic            i_hold,
    input  logic [NCS-1:0]  i_core_csb,
    input  logic            i_core_web,
    input  logic [3:0]      i_core_wmask,
    input  logic [AW-1:0]   i_core_addr,
    input  logic [31:0]     i_core_din,
    input  logic [NCS-1:0]  i_ldr_csb,
    input  logic            i_ldr_web,
    input  logic [3:0]      i_ldr_wmask,
    input  logic [AW-1:0]   i_ldr_addr,
    input  logic [31:0]     i_ldr_din,
    output logic [NCS-1:0]  o_mac_csb,
    output logic            o_mac_web,
    output logic [3:0]      o_mac_wmask,
    output logic [AW-1:0]   o_mac_addr,
    output logic [31:0]     o_mac_din
);

    genvar gi;
    generate
        for (gi = 0; gi < NCS; gi++) begin : g_csb
            assign o_mac_csb[gi] = i_hold ? i_ldr_csb[gi] : i_core_csb[gi];
        end
    endgenerate

    assign o_mac_web   = i_hold ? i_ldr_web   : i_core_web;
    assign o_mac_wmask = i_hold ? i_ldr_wmask : i_core_wmask;
    assign o_mac_addr  = i_hold ? i_ldr_addr  : i_core_addr;
    assign o_mac_din   = i_hold ? i_ldr_din   : i_core_din;

endmodule

// File: rtl/wb_sram_loader.sv
// -----------------------------------------------------------------------------
// wb_sram_loader
// Wishbone classic slave that lets the management SoC preload the IRAM A/B and
// DRAM macros while the core is held. A CTRL register (bit0 = hold) selects
// who owns port 0 of every macro.
//
// Ports:
//   clk, rst_n                   : clock (also macro port 0 clock), async low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i : Wishbone request
//   wbs_ack_o, wbs_dat_o         : one-cycle ack, read data (held until next read ack)
//   core_hold_o                  : core stall, registered copy of the hold bit
//   c_iram_* / c_dram_*          : core-side macro controls; c_*dout0* = macro dout
//   m_iram_* / m_dram_*          : macro-side controls; m_*dout0* = macro read data
// Address map (inside BASE_ADR page): [11:10] selects IRAM_A/IRAM_B/DRAM/CTRL,
// [AW+1:2] is the macro word address.
// -----------------------------------------------------------------------------
module wb_sram_loader
    import wb_sram_loader_pkg::*;
#(
    parameter logic [19:0] BASE_ADR = 20'h30000,
    parameter int          AW       = 8,
    parameter logic        HOLD_RST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    // Wishbone slave
    input  logic           wbs_stb_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    output logic           core_hold_o,
    // Core side
    input  logic           c_iram_csb0_A,
    input  logic           c_iram_csb0_B,
    input  logic           c_iram_web0,
    input  logic [3:0]     c_iram_wmask0,
    input  logic [AW-1:0]  c_iram_addr0,
    input  logic [31:0]    c_iram_din0,
    output logic [31:0]    c_iram_dout0_A,
    output logic [31:0]    c_iram_dout0_B,
    input  logic           c_dram_csb0,
    input  logic           c_dram_web0,
    input  logic [3:0]     c_dram_wmask0,
    input  logic [AW-1:0]  c_dram_addr0,
    input  logic [31:0]    c_dram_din0,
    output logic [31:0]    c_dram_dout0,
    // Macro side
    output logic           m_iram_csb0_A,
    output logic           m_iram_csb0_B,
    output logic           m_iram_web0,
    output logic [3:0]     m_iram_wmask0,
    output logic [AW-1:0]  m_iram_addr0,
    output logic [31:0]    m_iram_din0,
    input  logic [31:0]    m_iram_dout0_A,
    input  logic [31:0]    m_iram_dout0_B,
    output logic           m_dram_csb0,
    output logic           m_dram_web0,
    output logic [3:0]     m_dram_wmask0,
    output logic [AW-1:0]  m_dram_addr0,
    output logic [31:0]    m_dram_din0,
    input  logic [31:0]    m_dram_dout0
);

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic           r_hold;
    region_t        r_region;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_sel;
    logic [31:0]    r_rdata;

    logic           w_hit;
    logic           w_accept;
    region_t        w_region;
    logic [31:0]    w_ctrl_rd;
    logic [31:0]    w_sel_dout;
    logic           w_ack;
    logic           w_unused;

    logic [1:0]     w_ldr_iram_csb;   // [1] = B, [0] = A
    logic           w_ldr_iram_web;
    logic [3:0]     w_ldr_iram_wmask;
    logic [AW-1:0]  w_ldr_iram_addr;
    logic [31:0]    w_ldr_iram_din;
    logic [0:0]     w_ldr_dram_csb;
    logic           w_ldr_dram_web;
    logic [3:0]     w_ldr_dram_wmask;
    logic [AW-1:0]  w_ldr_dram_addr;
    logic [31:0]    w_ldr_dram_din;
    logic [1:0]     w_m_iram_csb;
    logic [0:0]     w_m_dram_csb;

    // Byte-offset bits carry no meaning for word-wide macros.
    assign w_unused = ^wbs_adr_i[1:0];

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign w_hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:12] == BASE_ADR);
    // Requests are only taken in IDLE; in ACK the master still has stb up.
    assign w_accept = (r_state == ST_IDLE) & w_hit;
    assign w_region = decode_region(wbs_adr_i);

    always_comb begin
        w_ctrl_rd                = '0;
        w_ctrl_rd[CTRL_HOLD_BIT] = r_hold;
    end

    always_comb begin
        unique case (r_region)
            REGION_IRAM_A: w_sel_dout = m_iram_dout0_A;
            REGION_IRAM_B: w_sel_dout = m_iram_dout0_B;
            REGION_DRAM:   w_sel_dout = m_dram_dout0;
            default:       w_sel_dout = 32'h0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((w_region == REGION_CTRL) || !r_hold) begin
                        w_state_next = ST_ACK;
                    end else if (wbs_we_i) begin
                        w_state_next = ST_WR;
                    end else begin
                        w_state_next = ST_RD1;
                    end
                end
            end
            ST_WR:   w_state_next = ST_ACK;
            ST_RD1:  w_state_next = ST_RD2;
            ST_RD2:  w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (loader-side macro drive and ack)
    // -------------------------------------------------------------------------
    always_comb begin
        w_ldr_iram_csb   = {IDLE_CSB, IDLE_CSB};
        w_ldr_iram_web   = IDLE_WEB;
        w_ldr_iram_wmask = IDLE_WMASK;
        w_ldr_iram_addr  = '0;
        w_ldr_iram_din   = IDLE_DIN;
        w_ldr_dram_csb   = IDLE_CSB;
        w_ldr_dram_web   = IDLE_WEB;
        w_ldr_dram_wmask = IDLE_WMASK;
        w_ldr_dram_addr  = '0;
        w_ldr_dram_din   = IDLE_DIN;
        w_ack            = 1'b0;
        unique case (r_state)
            ST_WR, ST_RD1: begin
                unique case (r_region)
                    REGION_IRAM_A, REGION_IRAM_B: begin
                        // A and B share every port signal except chip select.
                        if (r_region == REGION_IRAM_A) begin
                            w_ldr_iram_csb[0] = 1'b0;
                        end else begin
                            w_ldr_iram_csb[1] = 1'b0;
                        end
                        w_ldr_iram_addr = r_addr;
                        if (r_state == ST_WR) begin
                            w_ldr_iram_web   = 1'b0;
                            w_ldr_iram_wmask = r_sel;
                            w_ldr_iram_din   = r_wdata;
                        end
                    end
                    REGION_DRAM: begin
                        w_ldr_dram_csb  = 1'b0;
                        w_ldr_dram_addr = r_addr;
                        if (r_state == ST_WR) begin
                            w_ldr_dram_web   = 1'b0;
                            w_ldr_dram_wmask = r_sel;
                            w_ldr_dram_din   = r_wdata;
                        end
                    end
                    default: ;
                endcase
            end
            ST_ACK:  w_ack = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region <= REGION_IRAM_A;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_sel    <= '0;
        end else if (w_accept) begin
            r_region <= w_region;
            r_we     <= wbs_we_i;
            r_addr   <= wbs_adr_i[AW+1:2];
            r_wdata  <= wbs_dat_i;
            r_sel    <= wbs_sel_i;
        end
    end

    // -------------------------------------------------------------------------
    // Hold bit: updated at the end of the ACK cycle so an in-flight SRAM access
    // never sees a hold change, and the core sees it the cycle after ack.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= HOLD_RST;
        end else if ((r_state == ST_ACK) && (r_region == REGION_CTRL) && r_we && r_sel[0]) begin
            r_hold <= r_wdata[CTRL_HOLD_BIT];
        end
    end

    // -------------------------------------------------------------------------
    // Read data: changes only on reads, so write acks leave it untouched.
    // CTRL and hold=0 reads are resolved at accept; SRAM reads at end of RD2.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_accept && !wbs_we_i) begin
            if (w_region == REGION_CTRL) begin
                r_rdata <= w_ctrl_rd;
            end else if (!r_hold) begin
                r_rdata <= 32'h0;
            end
        end else if (r_state == ST_RD2) begin
            r_rdata <= w_sel_dout;
        end
    end

    assign wbs_ack_o   = w_ack;
    assign wbs_dat_o   = r_rdata;
    assign core_hold_o = r_hold;

    // -------------------------------------------------------------------------
    // Port muxes
    // -------------------------------------------------------------------------
    sram_port_mux #(
        .AW  (AW),
        .NCS (2)
    ) u_iram_mux (
        .i_hold       (r_hold),
        .i_core_csb   ({c_iram_csb0_B, c_iram_csb0_A}),
        .i_core_web   (c_iram_web0),
        .i_core_wmask (c_iram_wmask0),
        .i_core_addr  (c_iram_addr0),
        .i_core_din   (c_iram_din0),
        .i_ldr_csb    (w_ldr_iram_csb),
        .i_ldr_web    (w_ldr_iram_web),
        .i_ldr_wmask  (w_ldr_iram_wmask),
        .i_ldr_addr   (w_ldr_iram_addr),
        .i_ldr_din    (w_ldr_iram_din),
        .o_mac_csb    (w_m_iram_csb),
        .o_mac_web    (m_iram_web0),
        .o_mac_wmask  (m_iram_wmask0),
        .o_mac_addr   (m_iram_addr0),
        .o_mac_din    (m_iram_din0)
    );

    sram_port_mux #(
        .AW  (AW),
        .NCS (1)
    ) u_dram_mux (
        .i_hold       (r_hold),
        .i_core_csb   (c_dram_csb0),
        .i_core_web   (c_dram_web0),
        .i_core_wmask (c_dram_wmask0),
        .i_core_addr  (c_dram_addr0),
        .i_core_din   (c_dram_din0),
        .i_ldr_csb    (w_ldr_dram_csb),
        .i_ldr_web    (w_ldr_dram_web),
        .i_ldr_wmask  (w_ldr_dram_wmask),
        .i_ldr_addr   (w_ldr_dram_addr),
        .i_ldr_din    (w_ldr_dram_din),
        .o_mac_csb    (w_m_dram_csb),
        .o_mac_web    (m_dram_web0),
        .o_mac_wmask  (m_dram_wmask0),
        .o_mac_addr   (m_dram_addr0),
        .o_mac_din    (m_dram_din0)
    );

    assign m_iram_csb0_A = w_m_iram_csb[0];
    assign m_iram_csb0_B = w_m_iram_csb[1];
    assign m_dram_csb0   = w_m_dram_csb[0];

    // Macro read data always reaches the core, whoever owns the port.
    assign c_iram_dout0_A = m_iram_dout0_A;
    assign c_iram_dout0_B = m_iram_dout0_B;
    assign c_dram_dout0   = m_dram_dout0;

endmodule
